// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
// The optional statistics counters are enabled by defining ADDER_ARB_STATS_EN.
package adder_arb_pkg;

   localparam int DATA_W            = 32;
   localparam int ADDER_ARB_MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RESULT,
      DELIVER
   } arb_state_t;

   localparam logic [DATA_W-1:0] FP_ONE   = 32'h3F80_0000;
   localparam logic [DATA_W-1:0] FP_TWO   = 32'h4000_0000;
   localparam logic [DATA_W-1:0] FP_THREE = 32'h4040_0000;
   localparam logic [DATA_W-1:0] FP_FOUR  = 32'h4080_0000;

endpackage

// File: rtl/adder_arb_if.sv
// Requester-side and adder-side STB/BUSY bundle of the adder arbiter.
// slave is the arbiter's view, master the view of requesters plus adder.
interface adder_arb_if #(
   parameter int NUM_REQ = 4
);

   logic [NUM_REQ-1:0][adder_arb_pkg::DATA_W-1:0] req_a;
   logic [NUM_REQ-1:0][adder_arb_pkg::DATA_W-1:0] req_b;
   logic [NUM_REQ-1:0]                            req_STB;
   logic [NUM_REQ-1:0]                            req_BUSY;
   logic [adder_arb_pkg::DATA_W-1:0]              resp_sum;
   logic [NUM_REQ-1:0]                            resp_STB;
   logic [NUM_REQ-1:0]                            resp_BUSY;
   logic [adder_arb_pkg::DATA_W-1:0]              adder_input_a;
   logic [adder_arb_pkg::DATA_W-1:0]              adder_input_b;
   logic                                          adder_input_STB;
   logic                                          adder_BUSY;
   logic [adder_arb_pkg::DATA_W-1:0]              adder_output_sum;
   logic                                          adder_output_STB;
   logic                                          adder_output_module_BUSY;

   modport slave (
      input  req_a, req_b, req_STB, resp_BUSY,
      input  adder_BUSY, adder_output_sum, adder_output_STB,
      output req_BUSY, resp_sum, resp_STB,
      output adder_input_a, adder_input_b, adder_input_STB, adder_output_module_BUSY
   );

   modport master (
      output req_a, req_b, req_STB, resp_BUSY,
      output adder_BUSY, adder_output_sum, adder_output_STB,
      input  req_BUSY, resp_sum, resp_STB,
      input  adder_input_a, adder_input_b, adder_input_STB, adder_output_module_BUSY
   );

endinterface

// File: rtl/adder_rr_grant.sv
// Combinational round-robin pick: first active request at or above ptr,
// wrapping modulo NUM_REQ.
module adder_rr_grant
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   grant,
   output logic               valid
);

   function automatic int distance(input int idx, input logic [IDX_W-1:0] p);
      return (idx + NUM_REQ - int'(p)) % NUM_REQ;
   endfunction

   int best;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      best  = ADDER_ARB_MAX_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && (distance(i, ptr) < best)) begin
            best  = distance(i, ptr);
            grant = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one non-pipelined adder among NUM_REQ requesters, one operation in flight.
// Define ADDER_ARB_STATS_EN to add the stat_ops / stat_wait counters.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic        clk,
   input  logic        rst,
   adder_arb_if.slave  bus
`ifdef ADDER_ARB_STATS_EN
   ,
   output logic [31:0] stat_ops,
   output logic [31:0] stat_wait
`endif
);

   arb_state_t           state;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     owner;
   logic [IDX_W-1:0]     grant;
   logic                 grant_valid;
   logic [DATA_W-1:0]    op_a;
   logic [DATA_W-1:0]    op_b;
   logic [DATA_W-1:0]    result;
   logic                 issue_stb;
   logic                 out_busy;
   logic [NUM_REQ-1:0]   resp_stb;
   logic [NUM_REQ-1:0]   req_busy;
   logic                 deliver_done;

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
      return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
   endfunction

   adder_rr_grant #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_grant (
      .req   (bus.req_STB),
      .ptr   (rr_ptr),
      .grant (grant),
      .valid (grant_valid)
   );

   // Only the granted requester sees BUSY low, and only while idle.
   always_comb begin
      req_busy = '1;
      if (!rst && state == IDLE && grant_valid) begin
         req_busy[grant] = 1'b0;
      end
   end

   assign deliver_done = (state == DELIVER) && !bus.resp_BUSY[owner];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         result    <= '0;
         issue_stb <= 1'b0;
         out_busy  <= 1'b1;
         resp_stb  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  op_a      <= bus.req_a[grant];
                  op_b      <= bus.req_b[grant];
                  owner     <= grant;
                  issue_stb <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               // STB drops on the accepting edge so the adder sees the request once.
               if (!bus.adder_BUSY) begin
                  issue_stb <= 1'b0;
                  out_busy  <= 1'b0;
                  state     <= WAIT_RESULT;
               end
            end
            WAIT_RESULT: begin
               if (bus.adder_output_STB) begin
                  result          <= bus.adder_output_sum;
                  out_busy        <= 1'b1;
                  resp_stb[owner] <= 1'b1;
                  state           <= DELIVER;
               end
            end
            DELIVER: begin
               if (deliver_done) begin
                  resp_stb <= '0;
                  rr_ptr   <= next_ptr(owner);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADDER_ARB_STATS_EN
   // A wait cycle is an idle cycle where some asserted request is not the grant.
   logic waiting;
   assign waiting = (state == IDLE) && |(bus.req_STB & req_busy);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ops  <= '0;
         stat_wait <= '0;
      end else begin
         if (deliver_done) stat_ops  <= stat_ops + 32'd1;
         if (waiting)      stat_wait <= stat_wait + 32'd1;
      end
   end
`endif

   assign bus.req_BUSY                 = req_busy;
   assign bus.resp_sum                 = result;
   assign bus.resp_STB                 = resp_stb;
   assign bus.adder_input_a            = op_a;
   assign bus.adder_input_b            = op_b;
   assign bus.adder_input_STB          = issue_stb;
   assign bus.adder_output_module_BUSY = out_busy;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: per-requester op queues, a variable-latency
// adder model, and a monitor comparing each delivery with the expected owner and sum.
module tb_adder_arbiter;
   import adder_arb_pkg::*;

   localparam int N = 4;

   typedef struct {
      int x;
      int y;
   } op_t;

   typedef struct {
      int          owner;
      logic [31:0] sum;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adder_arb_if #(.NUM_REQ(N)) bus ();

`ifdef ADDER_ARB_STATS_EN
   logic [31:0] stat_ops;
   logic [31:0] stat_wait;
   adder_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .stat_ops  (stat_ops),
      .stat_wait (stat_wait)
   );
`else
   adder_arbiter #(.NUM_REQ(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   int          total = 0;
   int          bad = 0;
   op_t         rq[N][$];
   exp_t        sb[$];
   int          grant_log[$];
   int          model_ptr = 0;
   bit          inflight = 0;
   bit          deliver_pending = 0;
   int          pend_owner = 0;
   bit          rand_bp = 0;
   int          bp_target = -1;
   int          hold_cnt = 0;
   int          arb_accepts = 0;
   int          adder_accepts = 0;
   logic [31:0] last_sum = '0;

   // Exact float encoding of small non-negative integers (below 2**24).
   function automatic logic [31:0] float_of_int(input int n);
      int          p;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      p = 0;
      for (int k = 0; k < 31; k++) if (n >= (1 << k)) p = k;
      m = 32'(n) << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   function automatic int int_of_float(input logic [31:0] f);
      int          p;
      logic [31:0] m;
      if (f[30:0] == 31'h0) return 0;
      p = int'(f[30:23]) - 127;
      m = {8'h0, 1'b1, f[22:0]};
      return int'(m >> (23 - p));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   // Non-pipelined adder: random 1..4 cycle latency, BUSY until its result is taken.
   logic        a_busy = 1'b0;
   logic        a_out_stb = 1'b0;
   logic [31:0] a_sum = '0;
   int          a_lat = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         a_busy    <= 1'b0;
         a_out_stb <= 1'b0;
         a_sum     <= '0;
         a_lat     <= 0;
      end else if (a_out_stb) begin
         if (!bus.adder_output_module_BUSY) begin
            a_out_stb <= 1'b0;
            a_busy    <= 1'b0;
         end
      end else if (a_busy) begin
         if (a_lat <= 1) a_out_stb <= 1'b1;
         else            a_lat <= a_lat - 1;
      end else if (bus.adder_input_STB) begin
         a_busy        <= 1'b1;
         a_lat         <= int'($urandom_range(1, 4));
         a_sum         <= float_of_int(int_of_float(bus.adder_input_a) + int_of_float(bus.adder_input_b));
         adder_accepts <= adder_accepts + 1;
      end
   end

   assign bus.adder_BUSY       = a_busy;
   assign bus.adder_output_STB = a_out_stb;
   assign bus.adder_output_sum = a_sum;

   // Requester driver plus grant check against the round-robin rule.
   initial begin : driver
      logic [N-1:0] acc;
      logic [N-1:0] exp_acc;
      int           idx;
      exp_t         e;
      acc         = '0;
      bus.req_STB = '0;
      bus.req_a   = '0;
      bus.req_b   = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
               bus.req_STB[i] = 1'b1;
               bus.req_a[i]   = float_of_int(rq[i][0].x);
               bus.req_b[i]   = float_of_int(rq[i][0].y);
            end else begin
               bus.req_STB[i] = 1'b0;
            end
         end
         #1;
         acc     = bus.req_STB & ~bus.req_BUSY;
         exp_acc = '0;
         if (!rst && !inflight) begin
            for (int k = 0; k < N; k++) begin
               idx = (model_ptr + k) % N;
               if (exp_acc == '0 && bus.req_STB[idx]) exp_acc[idx] = 1'b1;
            end
         end
         if (bus.req_STB != '0) check("grant", 32'(acc), 32'(exp_acc));
         for (int i = 0; i < N; i++) begin
            if (acc[i] && rq[i].size() > 0) begin
               e.owner = i;
               e.sum   = float_of_int(rq[i][0].x + rq[i][0].y);
               sb.push_back(e);
               grant_log.push_back(i);
               inflight = 1'b1;
               arb_accepts++;
            end
         end
      end
   end

   // Monitor: drives resp_BUSY and pops the scoreboard on every delivery.
   initial begin : monitor
      logic [N-1:0] prev_stb;
      logic [31:0]  prev_sum;
      exp_t         e;
      bus.resp_BUSY = '0;
      prev_stb      = '0;
      prev_sum      = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            deliver_pending = 1'b0;
            hold_cnt        = 0;
            continue;
         end
         if (deliver_pending) begin
            inflight        = 1'b0;
            model_ptr       = (pend_owner + 1) % N;
            deliver_pending = 1'b0;
         end
         if (bus.resp_STB != '0) begin
            check("busy_while_busy", 32'(bus.req_BUSY), 32'hF);
            if (hold_cnt > 0) begin
               check("hold_stb", 32'(bus.resp_STB), 32'(prev_stb));
               check("hold_sum", bus.resp_sum, prev_sum);
               hold_cnt--;
               bus.resp_BUSY = '1;
            end else if (bp_target >= 0 && bus.resp_STB[bp_target]) begin
               hold_cnt      = 9;
               bp_target     = -1;
               prev_stb      = bus.resp_STB;
               prev_sum      = bus.resp_sum;
               bus.resp_BUSY = '1;
            end else if (rand_bp && $urandom_range(0, 2) == 0) begin
               bus.resp_BUSY = '1;
            end else begin
               bus.resp_BUSY = '0;
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_resp: resp_STB=%b with nothing outstanding", bus.resp_STB);
               end else begin
                  e = sb.pop_front();
                  check("resp_owner", 32'(bus.resp_STB), 32'(N'(1) << e.owner));
                  check("resp_sum", bus.resp_sum, e.sum);
                  last_sum        = bus.resp_sum;
                  pend_owner      = e.owner;
                  deliver_pending = 1'b1;
               end
            end
         end else begin
            bus.resp_BUSY = '0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit any_pending();
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
      return (sb.size() != 0) || inflight || deliver_pending;
   endfunction

   task automatic wait_drain(input int budget, input string name);
      int c = 0;
      while (any_pending() && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (c >= budget) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: still pending after %0d cycles, required drained", name, c);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req_BUSY"}, 32'(bus.req_BUSY), 32'hF);
      check({tag, "_resp_STB"}, 32'(bus.resp_STB), 32'h0);
      check({tag, "_resp_sum"}, bus.resp_sum, 32'h0);
      check({tag, "_in_STB"}, 32'(bus.adder_input_STB), 32'h0);
      check({tag, "_in_a"}, bus.adder_input_a, 32'h0);
      check({tag, "_in_b"}, bus.adder_input_b, 32'h0);
      check({tag, "_out_BUSY"}, 32'(bus.adder_output_module_BUSY), 32'h1);
   endtask

   task automatic do_reset(input bit check_now, input string tag);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      if (check_now) check_reset(tag);
      sb.delete();
      inflight        = 1'b0;
      deliver_pending = 1'b0;
      hold_cnt        = 0;
      model_ptr       = 0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   initial begin : main
      int   a0;
      int   c;
      int   enq;
      op_t  op;

      repeat (2) @(negedge clk);
      check_reset("init");
      @(posedge clk);
      #3 rst = 1'b0;

      // Single request: 1.0 + 2.0.
      a0 = adder_accepts;
      op = '{1, 2};
      rq[0].push_back(op);
      wait_drain(100, "single");
      check("single_sum", last_sum, FP_THREE);
      check("single_issue_count", 32'(adder_accepts - a0), 32'd1);

      // Simultaneous requests from 0 and 1 starting at pointer 0.
      do_reset(1'b0, "");
      grant_log.delete();
      op = '{1, 1};
      rq[0].push_back(op);
      op = '{2, 2};
      rq[1].push_back(op);
      wait_drain(200, "simul");
      check("simul_count", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         check("simul_first", 32'(grant_log[0]), 32'd0);
         check("simul_second", 32'(grant_log[1]), 32'd1);
      end
      check("simul_last_sum", last_sum, FP_FOUR);

      // Fairness: four requesters continuously active for eight operations.
      do_reset(1'b0, "");
      grant_log.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) begin
            op = '{int'($urandom_range(0, 5000)), int'($urandom_range(0, 5000))};
            rq[i].push_back(op);
         end
      wait_drain(400, "fair");
      check("fair_count", 32'(grant_log.size()), 32'd8);
      for (int k = 0; k < grant_log.size() && k < 8; k++)
         check("fair_order", 32'(grant_log[k]), 32'(k % N));
`ifdef ADDER_ARB_STATS_EN
      check("stat_ops", stat_ops, 32'd8);
      check("stat_wait_nonzero", 32'(stat_wait != 0), 32'd1);
`endif

      // Response backpressure on requester 2 with requester 0 waiting.
      grant_log.delete();
      bp_target = 2;
      op = '{300, 45};
      rq[2].push_back(op);
      c = 0;
      while (bus.resp_STB[2] !== 1'b1 && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("bp_reached_deliver", 32'(bus.resp_STB[2]), 32'd1);
      op = '{7, 8};
      rq[0].push_back(op);
      wait_drain(200, "bp");
      check("bp_count", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         check("bp_first", 32'(grant_log[0]), 32'd2);
         check("bp_second", 32'(grant_log[1]), 32'd0);
      end

      // Reset while the arbiter waits for the adder result.
      op = '{11, 22};
      rq[3].push_back(op);
      c = 0;
      while (bus.adder_output_module_BUSY !== 1'b0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("mid_in_wait", 32'(bus.adder_output_module_BUSY), 32'd0);
      do_reset(1'b1, "mid");
      repeat (10) @(negedge clk);
      check("mid_no_stale", 32'(bus.resp_STB), 32'h0);
      grant_log.delete();
      op = '{5, 6};
      rq[0].push_back(op);
      op = '{9, 10};
      rq[3].push_back(op);
      wait_drain(200, "mid");
      check("mid_count", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         check("mid_first", 32'(grant_log[0]), 32'd0);
         check("mid_second", 32'(grant_log[1]), 32'd3);
      end

      // Randomized traffic with random response backpressure.
      rand_bp = 1'b1;
      enq     = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk);
         #2;
         if (enq < 40 && $urandom_range(0, 3) == 0) begin
            op = '{int'($urandom_range(0, 100000)), int'($urandom_range(0, 100000))};
            rq[$urandom_range(0, N - 1)].push_back(op);
            enq++;
         end
      end
      wait_drain(3000, "random");
      rand_bp = 1'b0;

      check("issue_accounting", 32'(adder_accepts), 32'(arb_accepts));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one non-pipelined single-precision `adder` among `NUM_REQ` requesters in the neurosynapse datapath. It uses the codebase STB/BUSY handshake on both sides. It holds exactly one operation in flight, tags it with the owning requester, and returns the sum only to that requester. It sits between the ROCC-side neuron/accumulator units and the shared `adder` instance.

## Interface
- `NUM_REQ`, default 4, number of requesters, range 2..8.
- `IDX_W`, default `$clog2(NUM_REQ)`, width of the owner index. This is derived; do not override it.
- `clk`  in  1  the single clock.
- `rst`  in  1  reset. Asynchronous and active-high.
- `req_a`  in  NUM_REQ×32  operand A per requester.
- `req_b`  in  NUM_REQ×32  operand B per requester.
- `req_STB`  in  NUM_REQ  request valid per requester.
- `req_BUSY`  out  NUM_REQ  the arbiter cannot accept from this requester.
- `resp_sum`  out  32  result bus, shared by all requesters.
- `resp_STB`  out  NUM_REQ  result valid, one-hot to the owning requester.
- `resp_BUSY`  in  NUM_REQ  the requester cannot take its result.
- `adder_input_a`  out  32  operand A to the adder.
- `adder_input_b`  out  32  operand B to the adder.
- `adder_input_STB`  out  1  adder request valid.
- `adder_BUSY`  in  1  the adder cannot accept.
- `adder_output_sum`  in  32  adder result.
- `adder_output_STB`  in  1  adder result valid.
- `adder_output_module_BUSY`  out  1  the arbiter cannot take the adder result.

## Operation
- **Handshake rule.** A transfer occurs at a rising clk edge when STB=1 and the consumer's BUSY=0.
- **FSM states:** IDLE → ISSUE → WAIT_RESULT → DELIVER → IDLE.
- **IDLE**
  - The grant `g` is combinational: the first `i` with `req_STB[i]=1`, searching from `rr_ptr` upward and wrapping modulo NUM_REQ.
  - `req_BUSY[g]=0`. All other `req_BUSY` bits are 1. If there is no request, all bits are 1.
  - On a transfer, latch `req_a[g]` and `req_b[g]` into the operand registers, set `owner<=g`, and go to ISSUE.
- **ISSUE**
  - `adder_input_STB=1` and the operand registers drive the adder inputs.
  - At the edge where `adder_BUSY=0`, go to WAIT_RESULT and clear `adder_input_STB`.
  - STB must be low before `adder_BUSY` can drop again, so one request is never issued twice.
- **WAIT_RESULT**
  - `adder_output_module_BUSY=0`. In every other state it is 1.
  - At the edge where `adder_output_STB=1`, capture `adder_output_sum` into `result` and go to DELIVER.
- **DELIVER**
  - `resp_STB[owner]=1` and `resp_sum=result`.
  - At the edge where `resp_BUSY[owner]=0`, clear `resp_STB`, set `rr_ptr<=(owner+1) mod NUM_REQ`, and go to IDLE.
- **Fairness.** After owner `k` completes, `k` has the lowest priority. No requester waits more than NUM_REQ−1 operations.
- **Request stability.** A requester must hold its STB and operands stable until accepted. Requests that are not granted are untouched.
- **Result integrity.** `result` is not altered between capture and delivery.
- **Reset.** `rst`, at any time and mid-operation, forces IDLE, `rr_ptr=0`, `owner=0`, and clears `result`. The adder shares `rst`, so no stale result can reappear.

## Timing
- **Output reset values:**
  - `req_BUSY` all 1s while `rst=1`.
  - `resp_STB=0`.
  - `resp_sum=0`.
  - `adder_input_STB=0`.
  - `adder_input_a=0` and `adder_input_b=0`.
  - `adder_output_module_BUSY=1`.
- **Issue latency.** The request is accepted at edge T. `adder_input_STB` is high from T+1. With an idle adder, the adder accepts at edge T+1.
- **Delivery latency.** `resp_STB` rises one cycle after the edge that captures the adder result.
- **Arbiter overhead.** 3 cycles on top of the adder latency when both sides are ready.
- **Throughput.** One operation at a time, with no overlap. IDLE lasts at least 1 cycle between operations.
- **Output registering.** All outputs are registered except `req_BUSY`. `req_BUSY` is combinational from the state, `rr_ptr`, and `req_STB`.

## Configuration
- **`ADDER_ARB_STATS_EN` defined:**
  - Adds the output `stat_ops` (32 bits): completed deliveries.
  - Adds the output `stat_wait` (32 bits): cycles spent in IDLE with `req_STB!=0` but not yet accepted. This count is 0 for a single requester.
  - Both counters wrap, and both reset to 0.
- **`ADDER_ARB_STATS_EN` undefined:** those ports and counters do not exist, and all other behaviour is identical.

## Structure
- **Package `adder_arb_pkg`:**
  - the state enum `arb_state_t` (IDLE, ISSUE, WAIT_RESULT, DELIVER);
  - `ADDER_ARB_MAX_REQ=8`;
  - the float constants used by the bench.
- **Sub-module `adder_rr_grant`:**
  - purely combinational;
  - inputs: the `req` vector and `ptr`;
  - outputs: the grant index and a `valid` flag.
- **Top level.** The FSM, data registers and counters live in `adder_arbiter`.

## Test plan
- **Single request.** Req0 sends 0x3F800000+0x40000000 (1.0+2.0) → `resp_STB[0]` with `resp_sum=0x40400000`, and `adder_input_STB` is high for exactly one accept.
- **Simultaneous requests.** Req0 sends 1.0+1.0 and req1 sends 2.0+2.0 in the same cycle with `rr_ptr=0` → req0 receives 0x40000000 first, then req1 receives 0x40800000. `req_BUSY[1]` stays 1 until req0's delivery completes.
- **Fairness.** All 4 requesters are continuously active for 8 operations → grant order 0,1,2,3,0,1,2,3.
- **Response backpressure.** `resp_BUSY[2]` is held high for 10 cycles during DELIVER → `resp_STB[2]` and `resp_sum` stay stable, and no new request is accepted.
- **Reset mid-operation.** `rst` is pulsed during WAIT_RESULT → all outputs return to their reset values immediately, the next request is arbitrated from `rr_ptr=0`, and no stale `resp_STB` appears.
- **Statistics, with `ADDER_ARB_STATS_EN` defined.** Run the fairness scenario (4 requesters, 8 operations) → `stat_ops=8` and `stat_wait>0`. Build without the macro → the scenario still passes.
